// File: rtl/onchip_mem_bist_pkg.sv
// Shared types and constants for the on-chip RAM built-in self test.
package onchip_mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_LFSR  = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois form: taps are applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // All-zero is the LFSR lock-up state, so a zero seed starts from 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/onchip_mem_bist_if.sv
// Avalon-MM s1 port bundle between the BIST master and the single-port on-chip RAM.
interface onchip_mem_bist_if
    import onchip_mem_bist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport master (
        output mem_address,
        output mem_byteenable,
        output mem_chipselect,
        output mem_write,
        output mem_writedata,
        output mem_clken,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_byteenable,
        input  mem_chipselect,
        input  mem_write,
        input  mem_writedata,
        input  mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/onchip_mem_bist_patgen.sv
// Test-pattern generator: produces the data word for the access being issued this cycle.
module onchip_mem_bist_patgen
    import onchip_mem_bist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        pattern_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              load_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] lfsr_d;
    logic [DATA_W-1:0] lfsr_cur;

    // A load bypasses the register so the word issued on the load cycle is already the seed.
    always_comb begin
        lfsr_cur = load_i ? lfsr_seed(seed_i) : lfsr_q;
        lfsr_d   = advance_i ? lfsr_step(lfsr_cur) : lfsr_cur;
        case (pattern_i)
            PAT_ADDR:  data_o = DATA_W'(addr_i);
            PAT_NADDR: data_o = ~DATA_W'(addr_i);
            PAT_LFSR:  data_o = lfsr_cur;
            default:   data_o = seed_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/onchip_mem_bist.sv
// Fill/read-back self test for a single-port on-chip RAM, acting as its Avalon-MM master.
// One access per cycle; each readback is checked READ_LATENCY cycles after its read.
module onchip_mem_bist
    import onchip_mem_bist_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        pattern,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    onchip_mem_bist_if.master mem
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(READ_LATENCY - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_address_q, addr_d;
    logic              mem_cs_q, cs_d;
    logic              mem_wr_q, wr_d;
    logic [DATA_W-1:0] mem_wdata_q, wdata_d;
    logic [3:0]        mem_be_q, be_d;
    logic              mem_clken_q;
    logic [1:0]        pat_q, pat_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [1:0]        drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;

    logic [1:0]        gen_pat;
    logic [DATA_W-1:0] gen_seed;
    logic              gen_load;
    logic              gen_adv;
    logic [DATA_W-1:0] gen_data;
    logic              issue_rd;

    // Compare pipeline: index 0 is aligned with the issued read, index READ_LATENCY with its readdata.
    logic [READ_LATENCY:0]             vld_p_q;
    logic [READ_LATENCY:0][DATA_W-1:0] exp_p_q;
    logic [READ_LATENCY:0][ADDR_W-1:0] ea_p_q;
    logic                              mismatch;

    onchip_mem_bist_patgen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_patgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .pattern_i (gen_pat),
        .seed_i    (gen_seed),
        .addr_i    (addr_d),
        .load_i    (gen_load),
        .advance_i (gen_adv),
        .data_o    (gen_data)
    );

    assign mismatch = vld_p_q[READ_LATENCY] && (mem.mem_readdata != exp_p_q[READ_LATENCY]);

    always_comb begin
        state_d  = state_q;
        addr_d   = '0;
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        drain_d  = drain_q;
        pat_d    = pat_q;
        seed_d   = seed_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fa_d     = fa_q;
        fd_d     = fd_q;
        gen_pat  = pat_q;
        gen_seed = seed_q;
        gen_load = 1'b0;
        gen_adv  = 1'b0;
        issue_rd = 1'b0;

        if (mismatch) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) begin
                fa_d = ea_p_q[READ_LATENCY];
                fd_d = mem.mem_readdata;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_WRITE;
                    pat_d    = pattern;
                    seed_d   = seed;
                    gen_pat  = pattern;
                    gen_seed = seed;
                    gen_load = 1'b1;
                    gen_adv  = 1'b1;
                    cs_d     = 1'b1;
                    wr_d     = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    fa_d     = '0;
                    fd_d     = '0;
                end
            end
            ST_WRITE: begin
                cs_d    = 1'b1;
                gen_adv = 1'b1;
                if (mem_address_q == LAST_ADDR) begin
                    // Reload so the read phase regenerates exactly the written sequence.
                    state_d  = ST_READ;
                    gen_load = 1'b1;
                    issue_rd = 1'b1;
                end else begin
                    addr_d = mem_address_q + 1'b1;
                    wr_d   = 1'b1;
                end
            end
            ST_READ: begin
                if (mem_address_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d   = mem_address_q + 1'b1;
                    cs_d     = 1'b1;
                    gen_adv  = 1'b1;
                    issue_rd = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wdata_d = wr_d ? gen_data : '0;
        be_d    = cs_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            mem_clken_q   <= 1'b0;
            pat_q         <= '0;
            seed_q        <= '0;
            drain_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= '0;
            fa_q          <= '0;
            fd_q          <= '0;
            vld_p_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= addr_d;
            mem_cs_q      <= cs_d;
            mem_wr_q      <= wr_d;
            mem_wdata_q   <= wdata_d;
            mem_be_q      <= be_d;
            mem_clken_q   <= 1'b1;
            pat_q         <= pat_d;
            seed_q        <= seed_d;
            drain_q       <= drain_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_q         <= err_d;
            fa_q          <= fa_d;
            fd_q          <= fd_d;
            vld_p_q       <= {vld_p_q[READ_LATENCY-1:0], issue_rd};
        end
    end

    // Expected data/address need no reset: they are only looked at under vld_p_q.
    always_ff @(posedge clk) begin
        exp_p_q <= {exp_p_q[READ_LATENCY-1:0], gen_data};
        ea_p_q  <= {ea_p_q[READ_LATENCY-1:0], addr_d};
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = fa_q;
    assign first_err_data = fd_q;

    assign mem.mem_address    = mem_address_q;
    assign mem.mem_byteenable = mem_be_q;
    assign mem.mem_chipselect = mem_cs_q;
    assign mem.mem_write      = mem_wr_q;
    assign mem.mem_writedata  = mem_wdata_q;
    assign mem.mem_clken      = mem_clken_q;

endmodule

// File: tb/tb_onchip_mem_bist.sv
// Directed bench: two BIST instances (16-word RAM models, read latency 1 and 2) with hand-computed expectations.
module tb_onchip_mem_bist;

    logic        clk;
    logic        reset_n;
    logic        start_a;
    logic        start_b;
    logic [1:0]  pattern;
    logic [31:0] seed;

    logic        a_busy, a_done, a_pass;
    logic [15:0] a_err;
    logic [11:0] a_fa;
    logic [31:0] a_fd;
    logic        b_busy, b_done, b_pass;
    logic [3:0]  b_err;
    logic [11:0] b_fa;
    logic [31:0] b_fd;

    int checks;
    int errors;

    logic        stuck_en;
    logic        zero_rd;
    logic [31:0] ram_a [0:15];
    logic [31:0] ram_b [0:15];
    logic [31:0] rd1_b, rd2_b;

    int          n_wr, n_rd, first_wr_cyc, last_rd_cyc, done_cyc;
    logic [31:0] wr_data [0:15];
    logic [11:0] wr_addr [0:15];
    logic        c1_done, c1_busy;
    logic [15:0] c1_err;
    logic [11:0] c1_fa;
    logic [31:0] c1_fd;

    onchip_mem_bist_if #(.ADDR_W(12), .DATA_W(32)) ifa ();
    onchip_mem_bist_if #(.ADDR_W(12), .DATA_W(32)) ifb ();

    onchip_mem_bist #(.ADDR_W(12), .DATA_W(32), .DEPTH(16), .READ_LATENCY(1), .ERR_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .pattern(pattern), .seed(seed),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_err_addr(a_fa), .first_err_data(a_fd), .mem(ifa)
    );

    onchip_mem_bist #(.ADDR_W(12), .DATA_W(32), .DEPTH(16), .READ_LATENCY(2), .ERR_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .pattern(pattern), .seed(seed),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_addr(b_fa), .first_err_data(b_fd), .mem(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM A: latency 1, optional bit 5 stuck-at-0 at address 7.
    always @(posedge clk) begin
        if (ifa.mem_clken && ifa.mem_chipselect) begin
            if (ifa.mem_write)
                ram_a[ifa.mem_address[3:0]] <= (stuck_en && ifa.mem_address == 12'd7) ?
                                               (ifa.mem_writedata & ~32'h20) : ifa.mem_writedata;
            else
                ifa.mem_readdata <= ram_a[ifa.mem_address[3:0]];
        end
    end

    // RAM B: latency 2, optional all-zero readback.
    always @(posedge clk) begin
        if (ifb.mem_clken && ifb.mem_chipselect && ifb.mem_write)
            ram_b[ifb.mem_address[3:0]] <= ifb.mem_writedata;
        if (ifb.mem_clken && ifb.mem_chipselect && !ifb.mem_write)
            rd1_b <= ram_b[ifb.mem_address[3:0]];
        rd2_b <= rd1_b;
    end
    assign ifb.mem_readdata = zero_rd ? 32'h0 : rd2_b;

    function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Start a run in cycle 0 and log activity for cycles 1.. until done (bounded).
    task automatic run_bist(input bit use_b, input logic [1:0] p, input logic [31:0] s, input int pulse_cyc);
        logic cs, we, dn;
        logic [11:0] ad;
        logic [31:0] wd;
        @(posedge clk); #1;
        pattern = p;
        seed    = s;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        pattern = ~p;
        seed    = ~s;
        n_wr = 0; n_rd = 0; first_wr_cyc = -1; last_rd_cyc = -1; done_cyc = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            cs = use_b ? ifb.mem_chipselect : ifa.mem_chipselect;
            we = use_b ? ifb.mem_write      : ifa.mem_write;
            ad = use_b ? ifb.mem_address    : ifa.mem_address;
            wd = use_b ? ifb.mem_writedata  : ifa.mem_writedata;
            dn = use_b ? b_done : a_done;
            if (cyc == 1) begin
                c1_done = dn;
                c1_busy = use_b ? b_busy : a_busy;
                c1_err  = use_b ? 16'(b_err) : a_err;
                c1_fa   = use_b ? b_fa : a_fa;
                c1_fd   = use_b ? b_fd : a_fd;
            end
            if (cs && we) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (n_wr < 16) begin
                    wr_addr[n_wr] = ad;
                    wr_data[n_wr] = wd;
                end
                n_wr++;
            end
            if (cs && !we) begin
                n_rd++;
                last_rd_cyc = cyc;
            end
            if (dn) begin
                done_cyc = cyc;
                break;
            end
            start_a = (cyc == pulse_cyc) && !use_b;
            start_b = (cyc == pulse_cyc) && use_b;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done, a_pass, a_err, a_fa, a_fd, ifa.mem_address, ifa.mem_byteenable,
             ifa.mem_chipselect, ifa.mem_write, ifa.mem_writedata, ifa.mem_clken} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%b cs=%b clken=%b err=%h, required all zero",
                     a_busy, ifa.mem_chipselect, ifa.mem_clken, a_err);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifa.mem_clken !== 1'b1 || ifb.mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL clken_after_reset: got %b/%b required 1/1", ifa.mem_clken, ifb.mem_clken);
        end
        checks++;
        if ({a_busy, a_done, a_pass, ifa.mem_chipselect, ifa.mem_write, ifa.mem_byteenable} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b pass=%b cs=%b, required all 0",
                     a_busy, a_done, a_pass, ifa.mem_chipselect);
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_err, b_fa, b_fd, ifb.mem_chipselect} !== '0) begin
            errors++;
            $display("FAIL reset_b: busy=%b done=%b err=%h, required all 0", b_busy, b_done, b_err);
        end
    endtask

    task automatic test_pattern_addr();
        run_bist(1'b0, 2'd0, 32'h0, -1);
        checks++;
        if (first_wr_cyc !== 1) begin errors++; $display("FAIL first_write_cycle: got %0d required 1", first_wr_cyc); end
        checks++;
        if (c1_busy !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b required 1", c1_busy); end
        checks++;
        if (n_wr !== 16 || n_rd !== 16) begin errors++; $display("FAIL access_counts: got %0d/%0d required 16/16", n_wr, n_rd); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_addr[k] !== 12'(k) || wr_data[k] !== 32'(k)) begin
                errors++;
                $display("FAIL addr_pattern_word%0d: got addr %h data %h required %h/%h", k, wr_addr[k], wr_data[k], k, k);
            end
        end
        checks++;
        if (last_rd_cyc !== 32) begin errors++; $display("FAIL last_read_cycle: got %0d required 32", last_rd_cyc); end
        checks++;
        if (done_cyc !== 34) begin errors++; $display("FAIL done_cycle_a: got %0d required 34", done_cyc); end
        checks++;
        if (a_pass !== 1'b1 || a_err !== 16'd0 || a_fa !== 12'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL addr_status: pass=%b err=%0d fa=%h busy=%b required 1/0/0/0", a_pass, a_err, a_fa, a_busy);
        end
    endtask

    task automatic test_lfsr();
        logic [31:0] exp_v;
        run_bist(1'b0, 2'd2, 32'h1, -1);
        checks++;
        if (wr_data[1] !== 32'h8020_0003 || wr_data[2] !== 32'hC030_0002) begin
            errors++;
            $display("FAIL lfsr_literal: got %h %h required 80200003 c0300002", wr_data[1], wr_data[2]);
        end
        exp_v = 32'h1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_data[k] !== exp_v) begin
                errors++;
                $display("FAIL lfsr_word%0d: got %h required %h", k, wr_data[k], exp_v);
            end
            exp_v = lfsr_ref(exp_v);
        end
        checks++;
        if (a_pass !== 1'b1 || done_cyc !== 34) begin errors++; $display("FAIL lfsr_pass: pass=%b done_cyc=%0d required 1/34", a_pass, done_cyc); end
        run_bist(1'b0, 2'd2, 32'h0, -1);
        checks++;
        if (wr_data[0] !== 32'h1 || wr_data[1] !== 32'h8020_0003) begin
            errors++;
            $display("FAIL lfsr_zero_seed: got %h %h required 00000001 80200003", wr_data[0], wr_data[1]);
        end
        checks++;
        if (a_pass !== 1'b1) begin errors++; $display("FAIL lfsr_zero_seed_pass: got %b required 1", a_pass); end
    endtask

    task automatic test_stuck_bit();
        stuck_en = 1'b1;
        run_bist(1'b0, 2'd3, 32'hFFFF_FFFF, -1);
        stuck_en = 1'b0;
        checks++;
        if (wr_data[7] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL const_write: got %h required ffffffff", wr_data[7]); end
        checks++;
        if (a_err !== 16'd1) begin errors++; $display("FAIL stuck_err_count: got %0d required 1", a_err); end
        checks++;
        if (a_fa !== 12'd7) begin errors++; $display("FAIL stuck_first_addr: got %h required 007", a_fa); end
        checks++;
        if (a_fd !== 32'hFFFF_FFDF) begin errors++; $display("FAIL stuck_first_data: got %h required ffffffdf", a_fd); end
        checks++;
        if (a_pass !== 1'b0 || a_done !== 1'b1 || done_cyc !== 34) begin
            errors++;
            $display("FAIL stuck_status: pass=%b done=%b done_cyc=%0d required 0/1/34", a_pass, a_done, done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (a_done !== 1'b1 || a_err === 16'd0) begin
            errors++;
            $display("FAIL precondition_done: done=%b err=%0d required done 1 with errors", a_done, a_err);
        end
        run_bist(1'b0, 2'd0, 32'h0, 20);
        checks++;
        if (c1_done !== 1'b0) begin errors++; $display("FAIL done_drop: got %b required 0", c1_done); end
        checks++;
        if (c1_err !== 16'd0 || c1_fa !== 12'd0 || c1_fd !== 32'd0) begin
            errors++;
            $display("FAIL status_cleared: err=%0d fa=%h fd=%h required 0/0/0", c1_err, c1_fa, c1_fd);
        end
        checks++;
        if (done_cyc !== 34 || n_wr !== 16) begin
            errors++;
            $display("FAIL start_ignored: done_cyc=%0d writes=%0d required 34/16", done_cyc, n_wr);
        end
        checks++;
        if (a_pass !== 1'b1) begin errors++; $display("FAIL rerun_pass: got %b required 1", a_pass); end
    endtask

    task automatic test_saturate();
        zero_rd = 1'b1;
        run_bist(1'b1, 2'd1, 32'h0, -1);
        zero_rd = 1'b0;
        checks++;
        if (b_err !== 4'hF) begin errors++; $display("FAIL sat_err_count: got %0d required 15", b_err); end
        checks++;
        if (b_fa !== 12'd0 || b_fd !== 32'd0) begin errors++; $display("FAIL sat_first: fa=%h fd=%h required 0/0", b_fa, b_fd); end
        checks++;
        if (b_pass !== 1'b0 || done_cyc !== 35) begin errors++; $display("FAIL sat_status: pass=%b done_cyc=%0d required 0/35", b_pass, done_cyc); end
        run_bist(1'b1, 2'd0, 32'h0, -1);
        checks++;
        if (b_pass !== 1'b1 || b_err !== 4'd0) begin errors++; $display("FAIL lat2_pass: pass=%b err=%0d required 1/0", b_pass, b_err); end
        checks++;
        if (done_cyc !== 35 || last_rd_cyc !== 32) begin
            errors++;
            $display("FAIL lat2_timing: done_cyc=%0d last_rd=%0d required 35/32", done_cyc, last_rd_cyc);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        pattern = 2'd0;
        seed    = 32'h0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ifa.mem_chipselect !== 1'b1 || ifa.mem_write !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_write_precondition: cs=%b we=%b busy=%b required 1/1/1", ifa.mem_chipselect, ifa.mem_write, a_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_done, a_pass, a_err, a_fa, a_fd, ifa.mem_address, ifa.mem_byteenable,
             ifa.mem_chipselect, ifa.mem_write, ifa.mem_writedata, ifa.mem_clken} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b cs=%b addr=%h wd=%h clken=%b required all zero",
                     a_busy, ifa.mem_chipselect, ifa.mem_address, ifa.mem_writedata, ifa.mem_clken);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || ifa.mem_chipselect !== 1'b0 || ifa.mem_clken !== 1'b1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b cs=%b clken=%b done=%b required 0/0/1/0",
                     a_busy, ifa.mem_chipselect, ifa.mem_clken, a_done);
        end
        run_bist(1'b0, 2'd0, 32'h0, -1);
        checks++;
        if (done_cyc !== 34 || a_pass !== 1'b1 || n_wr !== 16) begin
            errors++;
            $display("FAIL rerun_after_reset: done_cyc=%0d pass=%b writes=%0d required 34/1/16", done_cyc, a_pass, n_wr);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        pattern  = 2'd0;
        seed     = 32'h0;
        stuck_en = 1'b0;
        zero_rd  = 1'b0;
        test_reset();
        test_pattern_addr();
        test_lfsr();
        test_stuck_bit();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/onchip_mem_bist.md
Name: onchip_mem_bist

Overview:
- Avalon-MM master sitting directly upstream of the 4096x32 single-port on-chip RAM; drives its s1 slave port (address, byteenable, chipselect, write, writedata, clken) and consumes its readdata.
- On start: fills every word with a selectable pattern, reads every word back, compares against the regenerated pattern, and reports pass/fail, error count and first failing location.
- Used for board bring-up and power-on memory checks before the Nios core is released.

Parameters:
- ADDR_W, 12, memory word-address width.
- DATA_W, 32, memory data width (fixed 32; byteenable is 4 bits).
- DEPTH, 4096, words tested (addresses 0..DEPTH-1); must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 2.
- READ_LATENCY, 1, cycles from read address to valid readdata; legal values 1 or 2 (2 if RAM output gets registered).
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- pattern  in  2  0=address, 1=~address, 2=LFSR from seed, 3=constant seed.
- seed  in  32  LFSR seed / constant; captured at start.
- busy  out  1  high from the cycle after start until DONE entered.
- done  out  1  level; high in DONE until next accepted start.
- pass  out  1  done & (err_count==0).
- err_count  out  ERR_W  mismatching words; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.
- first_err_data  out  32  readdata of first mismatch; 0 if none.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  4  always 4'hF while chipselect high, else 0.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  32  to RAM writedata.
- mem_clken  out  1  to RAM clken; high whenever not in reset.
- mem_readdata  in  32  from RAM readdata.

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; every output 0 except mem_clken=1 after reset release; counters, LFSR and capture registers cleared.
- States: IDLE -> WRITE on start; WRITE -> READ when write address DEPTH-1 issued; READ -> DRAIN when read address DEPTH-1 issued; DRAIN -> DONE after READ_LATENCY cycles; DONE -> WRITE on start.
- Accepting start in IDLE or DONE: captures pattern/seed, clears err_count, first_err_*, done; LFSR loaded with seed. start in WRITE/READ/DRAIN ignored.
- WRITE: one write per cycle, addr 0,1,...,DEPTH-1; chipselect=write=1; writedata = pattern(addr).
- READ: one read per cycle, addr 0..DEPTH-1; chipselect=1, write=0; LFSR reloaded with seed on READ entry so expected sequence matches.
- Pattern: 0 -> zero-extended addr; 1 -> ~(zero-extended addr); 2 -> 32-bit Galois LFSR, polynomial 0x80200003, advanced once per issued access, seed 0 replaced by 1; 3 -> seed.
- Compare: expected value and address delayed READ_LATENCY cycles in a shift pipeline alongside a valid bit; mismatch when valid & readdata != expected.
- On mismatch: err_count += 1 unless saturated; if first mismatch, capture address and readdata.
- Timing: start at cycle 0 -> first write in cycle 1; last read in cycle 2*DEPTH; done/pass rise in cycle 2*DEPTH+READ_LATENCY+1.
- Outputs registered; mem_* never glitch between accesses; chipselect low in IDLE/DRAIN/DONE.
- Reset mid-operation aborts immediately; no partial status retained.

Decomposition:
- Shared package onchip_mem_bist_pkg: state enum (IDLE, WRITE, READ, DRAIN, DONE), pattern code constants, LFSR polynomial constant.
- One sub-module: onchip_mem_bist_patgen (pattern code, seed, addr, load, advance -> 32-bit data); instanced once and reloaded between phases.

Test Plan:
- DEPTH=16, pattern=0, behavioural RAM model -> 16 writes data 0..15, 16 reads, done at cycle 34, pass=1, err_count=0.
- pattern=2, seed=0x1 -> writedata sequence 0x1,0x80200003,... matches reference LFSR model; pass=1.
- RAM model forcing bit 5 of address 7 stuck-at-0, pattern=3 seed=0xFFFFFFFF -> err_count=1, first_err_addr=7, first_err_data=0xFFFFFFDF, pass=0.
- ERR_W=4, all reads return 0, pattern=1 -> err_count saturates at 15, first_err_addr=0, first_err_data=0.
- start pulsed mid-READ -> ignored, completion timing unchanged; start again in DONE -> done drops next cycle, new run begins with cleared status.
- reset_n low during WRITE -> all outputs 0 within same cycle, state IDLE, clean rerun after release passes.
